mini_project_queue: RTL and testbench

- Single-lane queue monitor with two sensors: a back (entry) sensor `inx` and a front (exit) sensor `iny`.
- Each sensor feeds an edge-detect FSM that emits one pulse per person passing.
- An occupancy counter tracks people in queue (0..7) and raises empty/full/hold flags.
- A ROM indexed by {Tcount, Pcount} gives the expected waiting time for the next arrival, given Tcount active tellers.

---
 rtl/mini_project_queue_pkg.sv | 36 +++
 rtl/mini_project_queue_sensor_edge_fsm.sv | 49 ++++
 rtl/mini_project_queue.sv | 126 ++++++++++++
 tb/tb_mini_project_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mini_project_queue_pkg.sv
// Shared definitions for the queue monitor: widths, capacity, sensor FSM
// state encoding and the waiting-time table generator.
package mini_project_queue_pkg;

   localparam int CNT_W     = 3;
   localparam int WT_W      = 5;
   localparam int SERVICE_T = 3;
   localparam int TC_W      = 2;
   localparam int CAPACITY  = (2 ** CNT_W) - 1;
   localparam int ROM_IDX_W = TC_W + CNT_W;
   localparam int ROM_DEPTH = 2 ** ROM_IDX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PULSE     = 2'd1,
      WAIT_HIGH = 2'd2
   } sensor_state_e;

   // Packed waiting-time table indexed by {Tcount, Pcount}; entry idx sits at
   // bits [idx*WT_W +: WT_W]. No tellers means no meaningful estimate, so 0.
   function automatic logic [ROM_DEPTH*WT_W-1:0] wait_rom_init();
      logic [ROM_DEPTH*WT_W-1:0] tbl;
      int tellers;
      int people;
      int entry;
      tbl = '0;
      for (int idx = 0; idx < ROM_DEPTH; idx++) begin
         tellers = idx >> CNT_W;
         people  = idx % (2 ** CNT_W);
         entry   = (tellers == 0) ? 0 : (SERVICE_T * people) / tellers;
         tbl[idx*WT_W +: WT_W] = entry[WT_W-1:0];
      end
      return tbl;
   endfunction

endpackage

// File: rtl/mini_project_queue_sensor_edge_fsm.sv
// Falling-edge pulse generator for one active-low presence sensor.
// One single-cycle pulse is produced per 1->0 transition. After reset the
// FSM stays disarmed until it has seen a valid high level, so a sensor held
// low across reset release cannot produce a spurious pulse.
module queue_sensor_edge_fsm
   import mini_project_queue_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic sensor_i,
   input  logic sensor_vld_i,
   output logic pulse_o
);

   sensor_state_e state_q, state_d;
   logic          armed_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Arm once a trustworthy high level has been observed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         armed_q <= 1'b0;
      else if (sensor_vld_i && sensor_i) armed_q <= 1'b1;
   end

   // Next-state and pulse decode.
   always_comb begin
      state_d = state_q;
      pulse_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (!sensor_i && armed_q) state_d = PULSE;
         end
         PULSE: begin
            pulse_o = 1'b1;
            state_d = sensor_i ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (sensor_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/mini_project_queue.sv
// Single-lane queue monitor: entry/exit sensor edge detection, saturating
// occupancy counter with empty/full/hold flags, and a registered
// waiting-time lookup indexed by {Tcount, Pcount}.
// Optional: define MINI_PROJECT_QUEUE_SENSOR_SYNC_EN to put a 2-flop
// synchronizer (reset to 1) in front of each sensor FSM.
module mini_project_queue
   import mini_project_queue_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            inx,
   input  logic            iny,
   input  logic [TC_W-1:0] Tcount,
   output logic [CNT_W-1:0] Pcount,
   output logic            empty_flag,
   output logic            full_flag,
   output logic            Hold,
   output logic [WT_W-1:0] Wtime
);

   localparam logic [CNT_W-1:0]          CAP_CNT  = CNT_W'(CAPACITY);
   localparam logic [ROM_DEPTH*WT_W-1:0] WAIT_ROM = wait_rom_init();

   logic            inx_s, iny_s, sens_vld;
   logic            pci, pco;
   logic [CNT_W-1:0] pcount_q, pcount_d;
   logic            hold_q, hold_d;
   logic [WT_W-1:0] wtime_q;
   logic [ROM_IDX_W-1:0] rom_idx;

`ifdef MINI_PROJECT_QUEUE_SENSOR_SYNC_EN
   logic [1:0] x_sync_q, y_sync_q, vld_sync_q;

   // Two-flop synchronizers; the valid pipe marks when real samples arrive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_sync_q   <= 2'b11;
         y_sync_q   <= 2'b11;
         vld_sync_q <= 2'b00;
      end else begin
         x_sync_q   <= {x_sync_q[0], inx};
         y_sync_q   <= {y_sync_q[0], iny};
         vld_sync_q <= {vld_sync_q[0], 1'b1};
      end
   end

   assign inx_s    = x_sync_q[1];
   assign iny_s    = y_sync_q[1];
   assign sens_vld = vld_sync_q[1];
`else
   assign inx_s    = inx;
   assign iny_s    = iny;
   assign sens_vld = 1'b1;
`endif

   queue_sensor_edge_fsm u_entry_fsm (
      .clk          (clk),
      .reset        (reset),
      .sensor_i     (inx_s),
      .sensor_vld_i (sens_vld),
      .pulse_o      (pci)
   );

   queue_sensor_edge_fsm u_exit_fsm (
      .clk          (clk),
      .reset        (reset),
      .sensor_i     (iny_s),
      .sensor_vld_i (sens_vld),
      .pulse_o      (pco)
   );

   // Saturating occupancy update; simultaneous entry and exit cancel out.
   always_comb begin
      pcount_d = pcount_q;
      hold_d   = hold_q;
      case ({pci, pco})
         2'b10: begin
            if (pcount_q != CAP_CNT) begin
               pcount_d = pcount_q + 1'b1;
               hold_d   = 1'b0;
            end else begin
               hold_d   = 1'b1;
            end
         end
         2'b01: begin
            if (pcount_q != '0) begin
               pcount_d = pcount_q - 1'b1;
               hold_d   = 1'b0;
            end else begin
               hold_d   = 1'b1;
            end
         end
         default: begin
            pcount_d = pcount_q;
            hold_d   = hold_q;
         end
      endcase
   end

   // Occupancy and hold registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcount_q <= '0;
         hold_q   <= 1'b0;
      end else begin
         pcount_q <= pcount_d;
         hold_q   <= hold_d;
      end
   end

   assign rom_idx = {Tcount, pcount_q};

   // Registered waiting-time lookup from the current occupancy and tellers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wtime_q <= '0;
      else       wtime_q <= WAIT_ROM[rom_idx*WT_W +: WT_W];
   end

   assign Pcount     = pcount_q;
   assign Hold       = hold_q;
   assign empty_flag = (pcount_q == '0);
   assign full_flag  = (pcount_q == CAP_CNT);
   // An empty queue never reports a wait, even while the lookup catches up.
   assign Wtime      = empty_flag ? '0 : wtime_q;

endmodule

// File: tb/tb_mini_project_queue.sv
// Directed bench for mini_project_queue: per-cycle vector table for the
// basic flow and Tcount changes, then hand-written multi-cycle sequences for
// saturation, rejected requests, simultaneous events and mid-run reset.
module tb_mini_project_queue;

   logic       clk;
   logic       reset;
   logic       inx;
   logic       iny;
   logic [1:0] Tcount;
   logic [2:0] Pcount;
   logic       empty_flag;
   logic       full_flag;
   logic       Hold;
   logic [4:0] Wtime;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic       rst;
      logic       x;
      logic       y;
      logic [1:0] t;
      logic [2:0] p;
      logic       e;
      logic       f;
      logic       h;
      logic [4:0] w;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   mini_project_queue dut (
      .clk        (clk),
      .reset      (reset),
      .inx        (inx),
      .iny        (iny),
      .Tcount     (Tcount),
      .Pcount     (Pcount),
      .empty_flag (empty_flag),
      .full_flag  (full_flag),
      .Hold       (Hold),
      .Wtime      (Wtime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic r, input logic x, input logic y, input int t,
                                input int p, input logic e, input logic f, input logic h,
                                input int w);
      vec_t v;
      v.rst = r; v.x = x; v.y = y; v.t = t[1:0];
      v.p = p[2:0]; v.e = e; v.f = f; v.h = h; v.w = w[4:0];
      return v;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_x();
      inx = 1'b0; step();
      inx = 1'b1; step();
   endtask

   task automatic pulse_y();
      iny = 1'b0; step();
      iny = 1'b1; step();
   endtask

   initial begin
      //           rst x  y  T   P  e  f  h  W
      vecs[0]  = mkv(1, 1, 1, 1,  0, 1, 0, 0, 0);
      vecs[1]  = mkv(0, 1, 1, 1,  0, 1, 0, 0, 0);
      vecs[2]  = mkv(0, 0, 1, 1,  0, 1, 0, 0, 0);
      vecs[3]  = mkv(0, 0, 1, 1,  1, 0, 0, 0, 0);
      vecs[4]  = mkv(0, 0, 1, 1,  1, 0, 0, 0, 3);
      vecs[5]  = mkv(0, 0, 1, 1,  1, 0, 0, 0, 3);
      vecs[6]  = mkv(0, 0, 1, 1,  1, 0, 0, 0, 3);
      vecs[7]  = mkv(0, 0, 1, 1,  1, 0, 0, 0, 3);
      vecs[8]  = mkv(0, 0, 1, 1,  1, 0, 0, 0, 3);
      vecs[9]  = mkv(0, 1, 1, 1,  1, 0, 0, 0, 3);
      vecs[10] = mkv(0, 1, 0, 1,  1, 0, 0, 0, 3);
      vecs[11] = mkv(0, 1, 0, 1,  0, 1, 0, 0, 0);
      vecs[12] = mkv(0, 1, 1, 1,  0, 1, 0, 0, 0);
      vecs[13] = mkv(0, 0, 1, 1,  0, 1, 0, 0, 0);
      vecs[14] = mkv(0, 1, 1, 1,  1, 0, 0, 0, 0);
      vecs[15] = mkv(0, 1, 1, 1,  1, 0, 0, 0, 3);
      vecs[16] = mkv(0, 1, 1, 3,  1, 0, 0, 0, 1);
      vecs[17] = mkv(0, 1, 1, 3,  1, 0, 0, 0, 1);
      vecs[18] = mkv(0, 1, 1, 0,  1, 0, 0, 0, 0);
      vecs[19] = mkv(0, 1, 1, 0,  1, 0, 0, 0, 0);
      vecs[20] = mkv(0, 1, 1, 2,  1, 0, 0, 0, 1);
      vecs[21] = mkv(0, 1, 1, 2,  1, 0, 0, 0, 1);
      vecs[22] = mkv(0, 1, 0, 2,  1, 0, 0, 0, 1);
      vecs[23] = mkv(0, 1, 1, 2,  0, 1, 0, 0, 0);

      reset = 1'b1; inx = 1'b1; iny = 1'b1; Tcount = 2'd1;

      for (int i = 0; i < NVEC; i++) begin
         reset  = vecs[i].rst;
         inx    = vecs[i].x;
         iny    = vecs[i].y;
         Tcount = vecs[i].t;
         step();
         check($sformatf("vec%0d.Pcount", i), Pcount, vecs[i].p);
         check($sformatf("vec%0d.empty", i), empty_flag, vecs[i].e);
         check($sformatf("vec%0d.full", i), full_flag, vecs[i].f);
         check($sformatf("vec%0d.Hold", i), Hold, vecs[i].h);
         check($sformatf("vec%0d.Wtime", i), Wtime, vecs[i].w);
      end

      // Fill to capacity with two tellers.
      Tcount = 2'd2;
      for (int i = 1; i <= 7; i++) begin
         pulse_x();
         check($sformatf("fill%0d.Pcount", i), Pcount, i);
      end
      step();
      check("full.flag", full_flag, 1);
      check("full.Wtime", Wtime, 10);
      check("full.Hold", Hold, 0);
      check("full.empty", empty_flag, 0);

      // Enqueue rejected at full, then a dequeue clears Hold.
      pulse_x();
      check("over.Pcount", Pcount, 7);
      check("over.Hold", Hold, 1);
      check("over.full", full_flag, 1);
      pulse_y();
      check("deq.Pcount", Pcount, 6);
      check("deq.Hold", Hold, 0);
      check("deq.full", full_flag, 0);
      step();
      check("deq.Wtime", Wtime, 9);

      // Drain, then a rejected dequeue at empty.
      for (int i = 0; i < 6; i++) pulse_y();
      check("drain.Pcount", Pcount, 0);
      check("drain.empty", empty_flag, 1);
      pulse_y();
      check("under.Pcount", Pcount, 0);
      check("under.empty", empty_flag, 1);
      check("under.Hold", Hold, 1);
      check("under.Wtime", Wtime, 0);

      // Simultaneous events at empty leave both count and Hold alone.
      inx = 1'b0; iny = 1'b0; step();
      inx = 1'b1; iny = 1'b1; step();
      check("simul0.Pcount", Pcount, 0);
      check("simul0.Hold", Hold, 1);

      pulse_x();
      check("refill.Hold", Hold, 0);
      pulse_x();
      pulse_x();
      check("refill.Pcount", Pcount, 3);
      inx = 1'b0; iny = 1'b0; step();
      inx = 1'b1; iny = 1'b1; step();
      check("simul3.Pcount", Pcount, 3);
      check("simul3.Hold", Hold, 0);
      step();
      check("simul3.Wtime", Wtime, 4);

      // Reset asserted mid-operation with the entry sensor held low.
      pulse_x();
      pulse_x();
      check("pre_rst.Pcount", Pcount, 5);
      inx = 1'b0; step();
      reset = 1'b1; #1;
      check("rst.Pcount", Pcount, 0);
      check("rst.empty", empty_flag, 1);
      check("rst.Hold", Hold, 0);
      check("rst.Wtime", Wtime, 0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("held_low%0d.Pcount", i), Pcount, 0);
      end
      inx = 1'b1; step();
      check("rearm.Pcount", Pcount, 0);
      inx = 1'b0; step();
      step();
      check("after_rearm.Pcount", Pcount, 1);
      inx = 1'b1; step();
      check("after_rearm.Wtime", Wtime, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
